ntt_coeff_ingest: RTL
=====================

# ntt_coeff_ingest

Input front end of the NTT datapath, directly upstream of the bit-reversal loader. It accepts one polynomial (`RING_SIZE` coefficients) at a time from the host over a ready/valid stream and reduces each coefficient into [0, Q). A small FIFO buffers the stream, and the block drives the loader's `valid`/`din` one coefficient per cycle. It resets the loader between polynomials, waits for its `done`, then hands off to the NTT core with a start pulse and holds off the next polynomial while the core is busy.

## Interface
- `Q`, 12289: coefficient modulus; must satisfy 2Q < 2^`DATA_SIZE_ARB`.
- `FIFO_DEPTH`, 4: coefficient FIFO entries, power of two, ≥2.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `s_data`  in  `DATA_SIZE_ARB`  host coefficient.
- `s_valid`  in  1  host data valid.
- `s_ready`  out  1  block can accept.
- `br_reset`  out  1  one-cycle synchronous reset pulse to the loader.
- `br_valid`  out  1  coefficient valid to the loader.
- `br_dout`  out  `DATA_SIZE_ARB`  reduced coefficient to the loader.
- `br_done`  in  1  loader has stored all entries (level, sticky until `br_reset`).
- `core_start`  out  1  one-cycle pulse: polynomial loaded.
- `core_busy`  in  1  NTT core running.
- `frame_err`  out  1  last started frame contained an out-of-range input.

## Operation
- Transfer: `s_valid && s_ready` at a rising edge.
- `s_ready` = FIFO not full AND `acc_cnt` != `RING_SIZE`. It is registered-state only, with no combinational path from `s_valid`.
- `acc_cnt` is `$clog2(RING_SIZE)+1` bits. It increments per transfer and clears on the WAIT_CORE→IDLE transition.
- Reduction at FIFO write, computed in `DATA_SIZE_ARB+1` bits:
  - x < Q: store x.
  - Q ≤ x < 2Q: store x−Q.
  - x ≥ 2Q: store 0 and set the internal sticky `range_err`.
- `range_err` clears with `acc_cnt`.
- FIFO push and pop in the same cycle are legal; there is no push-when-full bypass.
- FSM states:
  - IDLE: → CLEAR when FIFO is non-empty and `core_busy`=0.
  - CLEAR: `br_reset`=1 for exactly one cycle. → LOAD.
  - LOAD:
    - Each cycle the FIFO is non-empty: pop, drive `br_valid`=1 and `br_dout` (registered), increment `emit_cnt`.
    - When `emit_cnt` reaches `RING_SIZE`, → DRAIN.
    - FIFO empty: `br_valid`=0 and the FSM waits.
  - DRAIN: `br_valid`=0. → START when `br_done`=1.
  - START: `core_start`=1 for one cycle; `frame_err` ← `range_err`. → WAIT_CORE.
  - WAIT_CORE: → IDLE on the first cycle where `core_busy`=0. The core must raise `core_busy` on the cycle after `core_start`.
- Coefficients are never reordered or dropped. Exactly `RING_SIZE` `br_valid` pulses occur per frame.
- Async reset at any point: FIFO emptied, all counters and `range_err` cleared, FSM → IDLE, all outputs 0. A partially loaded frame is discarded; the next frame starts from CLEAR.

## Timing
- Reset values: `s_ready`=0 while `reset`=1, then 1 after release (FIFO empty). `br_reset`, `br_valid`, `br_dout`, `core_start` and `frame_err` are all 0.
- Transfer at edge N → FIFO write at edge N. CLEAR follows at edge N+1 (first frame, IDLE). The coefficient appears on `br_valid` after edge N+2.
- In LOAD, a steady stream sustains one coefficient per cycle.
- `br_valid` never asserts in the same cycle as `br_reset`.
- `core_start` asserts at the earliest one cycle after `br_done` is sampled high.
- During WAIT_CORE and DRAIN, `s_ready` may remain 1 only until `acc_cnt`=`RING_SIZE`. Since all `RING_SIZE` transfers have occurred by then, `s_ready` is 0 in both states.

## Structure
- Package `ntt_ingest_pkg`: FSM state enum (IDLE, CLEAR, LOAD, DRAIN, START, WAIT_CORE) and the count-width localparam.
- Widths come from `defines.v` (`DATA_SIZE_ARB`, `RING_SIZE`).
- One sub-module, `coeff_fifo`: synchronous FIFO, async reset, with full/empty flags and parameter `FIFO_DEPTH`.
- Reduction and the FSM live in the top module.

## Test plan
- Reset: with `reset` held, all outputs are 0. The cycle after release, `s_ready`=1 and there is no `br_reset`.
- Full frame: with `RING_SIZE`=8, send 0..7 back-to-back.
  - One `br_reset` pulse, then 8 consecutive `br_valid` cycles with data 0..7.
  - `s_ready`=0 after the 8th transfer.
  - `core_start` pulses once after `br_done`.
- Reduction: inputs 12288, 12289, 24577, 24578 → `br_dout` 12288, 0, 12288, 0. `frame_err`=1 after START; a following clean frame gives `frame_err`=0.
- Backpressure and gaps: `s_valid` random at 50%. Output order and count are exact, and there are no `br_valid` gaps beyond FIFO-empty cycles.
- Core busy: hold `core_busy` for 20 cycles after `core_start`.
  - `s_ready` stays 0 throughout and rises the cycle after IDLE is entered.
  - The next `br_reset` occurs only after `core_busy` falls.
- Mid-load reset: assert `reset` asynchronously after 3 `br_valid` pulses. Outputs go 0 immediately. A fresh frame 10..17 then loads in full with the correct data.

Source files
------------

// File: rtl/ntt_ingest_pkg.sv
// Shared types and widths for the NTT coefficient ingest front end.
// Widths normally come from the project defines; the fallbacks keep the package self-contained.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 16
`endif
`ifndef RING_SIZE
`define RING_SIZE 8
`endif

package ntt_ingest_pkg;

    localparam int DATA_W = `DATA_SIZE_ARB;
    localparam int RING_N = `RING_SIZE;
    localparam int CNT_W  = $clog2(RING_N) + 1;
    localparam logic [CNT_W-1:0] RING_CNT = CNT_W'(RING_N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_DRAIN,
        S_START,
        S_WAIT_CORE
    } ingest_state_t;

endpackage

// File: rtl/coeff_fifo.sv
// Small synchronous FIFO for reduced coefficients; combinational read of the head entry.
module coeff_fifo #(
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ntt_coeff_ingest.sv
// Host-side ingest: reduces coefficients mod Q, buffers them, feeds the bit-reversal
// loader one per cycle and hands each full polynomial to the NTT core.
module ntt_coeff_ingest
    import ntt_ingest_pkg::*;
#(
    parameter int Q          = 12289,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              br_reset,
    output logic              br_valid,
    output logic [DATA_W-1:0] br_dout,
    input  logic              br_done,
    output logic              core_start,
    input  logic              core_busy,
    output logic              frame_err
);

    localparam logic [DATA_W-1:0] Q_W  = DATA_W'(Q);
    localparam logic [DATA_W:0]   Q2_X = (DATA_W+1)'(2 * Q);

    function automatic logic over_range(input logic [DATA_W-1:0] x);
        return {1'b0, x} >= Q2_X;
    endfunction

    // Inputs at or beyond 2Q cannot be reduced by one subtraction; they map to 0.
    function automatic logic [DATA_W-1:0] reduce_coeff(input logic [DATA_W-1:0] x);
        if (over_range(x))          return '0;
        if ({1'b0, x} >= {1'b0, Q_W}) return x - Q_W;
        return x;
    endfunction

    ingest_state_t     state_q, state_d;
    logic              alive_q, alive_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]  emit_cnt_q, emit_cnt_d;
    logic              range_err_q, range_err_d;
    logic              br_reset_q, br_reset_d;
    logic              br_valid_q, br_valid_d;
    logic [DATA_W-1:0] br_dout_q, br_dout_d;
    logic              core_start_q, core_start_d;
    logic              frame_err_q, frame_err_d;

    logic              fifo_full, fifo_empty;
    logic              push, pop;
    logic [DATA_W-1:0] fifo_wdata, fifo_rdata;

    // alive_q keeps s_ready low while reset is held without a path from the reset pin.
    assign s_ready    = alive_q && !fifo_full && (acc_cnt_q != RING_CNT);
    assign push       = s_valid && s_ready;
    assign fifo_wdata = reduce_coeff(s_data);
    // Popping already in CLEAR lets the first coefficient follow the loader reset directly.
    assign pop        = ((state_q == S_CLEAR) || (state_q == S_LOAD)) &&
                        !fifo_empty && (emit_cnt_q != RING_CNT);

    coeff_fifo #(
        .WIDTH      (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (fifo_wdata),
        .rd_en   (pop),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        alive_d      = 1'b1;
        acc_cnt_d    = acc_cnt_q + CNT_W'(push);
        emit_cnt_d   = emit_cnt_q + CNT_W'(pop);
        range_err_d  = range_err_q | (push && over_range(s_data));
        br_reset_d   = 1'b0;
        br_valid_d   = pop;
        br_dout_d    = pop ? fifo_rdata : br_dout_q;
        core_start_d = 1'b0;
        frame_err_d  = frame_err_q;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !core_busy) begin
                    state_d    = S_CLEAR;
                    br_reset_d = 1'b1;
                    emit_cnt_d = '0;
                end
            end
            S_CLEAR: state_d = S_LOAD;
            S_LOAD: begin
                if (emit_cnt_d == RING_CNT) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (br_done) begin
                    state_d      = S_START;
                    core_start_d = 1'b1;
                    frame_err_d  = range_err_q;
                end
            end
            S_START: state_d = S_WAIT_CORE;
            S_WAIT_CORE: begin
                if (!core_busy) begin
                    state_d     = S_IDLE;
                    acc_cnt_d   = '0;
                    emit_cnt_d  = '0;
                    range_err_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            alive_q      <= 1'b0;
            acc_cnt_q    <= '0;
            emit_cnt_q   <= '0;
            range_err_q  <= 1'b0;
            br_reset_q   <= 1'b0;
            br_valid_q   <= 1'b0;
            br_dout_q    <= '0;
            core_start_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            alive_q      <= alive_d;
            acc_cnt_q    <= acc_cnt_d;
            emit_cnt_q   <= emit_cnt_d;
            range_err_q  <= range_err_d;
            br_reset_q   <= br_reset_d;
            br_valid_q   <= br_valid_d;
            br_dout_q    <= br_dout_d;
            core_start_q <= core_start_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign br_reset   = br_reset_q;
    assign br_valid   = br_valid_q;
    assign br_dout    = br_dout_q;
    assign core_start = core_start_q;
    assign frame_err  = frame_err_q;

endmodule
